// File: rtl/breath_pkg.sv
// Shared encodings and defaults for the LED breathing controller.
// Mode and state enums used by the sequencer and its timebase.
package breath_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ON     = 2'd1,
    MODE_BREATH = 2'd2,
    MODE_SINGLE = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ON      = 3'd1,
    ST_UP      = 3'd2,
    ST_HOLD_HI = 3'd3,
    ST_DOWN    = 3'd4,
    ST_HOLD_LO = 3'd5
  } state_e;

  localparam int TICK_DIV_DEF = 100;
  localparam int DUTY_MAX_DEF = 1000;
  localparam int DW_DEF       = 10;

  function automatic logic is_busy(input state_e s);
    return (s == ST_UP) || (s == ST_HOLD_HI) ||
           (s == ST_DOWN) || (s == ST_HOLD_LO);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Tick prescaler and PWM frame counter.
// frame_end_o is registered and aligned to the last cycle of each frame.
module pwm_timebase
  import breath_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DUTY_MAX = DUTY_MAX_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [DW-1:0] frame_cnt_o,
  output logic          frame_end_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] FRAME_LAST = DW'(DUTY_MAX - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] frame_cnt_q, frame_cnt_d;
  logic          frame_end_q, frame_end_d;
  logic          tick;

  always_comb begin
    tick        = (tick_cnt_q == TICK_LAST);
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    frame_cnt_d = frame_cnt_q;
    if (tick) begin
      frame_cnt_d = (frame_cnt_q == FRAME_LAST) ?
                    '0 : frame_cnt_q + DW'(1);
    end
    // look ahead so the flop is high while the counters sit at their last value
    frame_end_d = (tick_cnt_d == TICK_LAST) &&
                  (frame_cnt_d == FRAME_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q  <= '0;
      frame_cnt_q <= '0;
      frame_end_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign frame_end_o = frame_end_q;

endmodule

// File: rtl/breath_seq_ctrl.sv
// LED breathing sequencer: command handshake, mode FSM, PWM compare.
// Define BREATH_GAMMA_EN for a squared (gamma) duty-to-compare map.
module breath_seq_ctrl
  import breath_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DUTY_MAX = DUTY_MAX_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_mode,
  input  logic [7:0]    cmd_hold,
  output logic          busy,
  output logic [2:0]    state_o,
  output logic [DW-1:0] duty,
  output logic          frame_end,
  output logic          led
);

  localparam logic [DW-1:0] DMAX = DW'(DUTY_MAX);

  logic [DW-1:0] frame_cnt;
  logic          fe;

  pwm_timebase #(
    .TICK_DIV (TICK_DIV),
    .DUTY_MAX (DUTY_MAX),
    .DW       (DW)
  ) u_timebase (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .frame_cnt_o (frame_cnt),
    .frame_end_o (fe)
  );

  state_e        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [7:0]    hcnt_q, hcnt_d;
  logic [7:0]    hold_q, hold_d;
  mode_e         mact_q, mact_d;
  logic          pvld_q, pvld_d;
  mode_e         pmode_q, pmode_d;
  logic [7:0]    phold_q, phold_d;
  logic          busy_q, busy_d;
  logic          led_q, led_d;
  logic [DW-1:0] cmp;

`ifdef BREATH_GAMMA_EN
  logic [2*DW-1:0] sq;
  assign sq  = duty_q * duty_q;
  assign cmp = sq[2*DW-1:DW];
`else
  assign cmp = duty_q;
`endif

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hcnt_d  = hcnt_q;
    hold_d  = hold_q;
    mact_d  = mact_q;
    pvld_d  = pvld_q;
    pmode_d = pmode_q;
    phold_d = phold_q;

    if (cmd_valid && !pvld_q) begin
      pvld_d  = 1'b1;
      pmode_d = mode_e'(cmd_mode);
      phold_d = cmd_hold;
    end

    if (fe) begin
      if (pvld_q) begin
        pvld_d = 1'b0;
        hcnt_d = '0;
        hold_d = phold_q;
        mact_d = pmode_q;
        unique case (1'b1)
          pmode_q == MODE_OFF: begin
            state_d = ST_OFF;
            duty_d  = '0;
          end
          pmode_q == MODE_ON: begin
            state_d = ST_ON;
            duty_d  = DMAX;
          end
          pmode_q == MODE_BREATH,
          pmode_q == MODE_SINGLE: begin
            state_d = ST_UP;
          end
        endcase
      end else begin
        unique case (state_q)
          ST_UP: begin
            if (duty_q >= DMAX - DW'(1)) begin
              duty_d  = DMAX;
              state_d = ST_HOLD_HI;
            end else begin
              duty_d = duty_q + DW'(1);
            end
          end
          ST_HOLD_HI: begin
            if (hcnt_q == hold_q) begin
              hcnt_d  = '0;
              state_d = ST_DOWN;
            end else begin
              hcnt_d = hcnt_q + 8'd1;
            end
          end
          ST_DOWN: begin
            if (duty_q <= DW'(1)) begin
              duty_d  = '0;
              state_d = (mact_q == MODE_SINGLE) ?
                        ST_OFF : ST_HOLD_LO;
            end else begin
              duty_d = duty_q - DW'(1);
            end
          end
          ST_HOLD_LO: begin
            if (hcnt_q == hold_q) begin
              hcnt_d  = '0;
              state_d = ST_UP;
            end else begin
              hcnt_d = hcnt_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end

    busy_d = is_busy(state_d);
    led_d  = (frame_cnt < cmp);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_OFF;
      duty_q  <= '0;
      hcnt_q  <= '0;
      hold_q  <= '0;
      mact_q  <= MODE_OFF;
      pvld_q  <= 1'b0;
      pmode_q <= MODE_OFF;
      phold_q <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      hcnt_q  <= hcnt_d;
      hold_q  <= hold_d;
      mact_q  <= mact_d;
      pvld_q  <= pvld_d;
      pmode_q <= pmode_d;
      phold_q <= phold_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign cmd_ready = !pvld_q;
  assign busy      = busy_q;
  assign state_o   = state_q;
  assign duty      = duty_q;
  assign frame_end = fe;
  assign led       = led_q;

endmodule

// File: tb/tb_breath_seq_ctrl.sv
// Directed bench for breath_seq_ctrl with a 32-cycle PWM frame.
// TICK_DIV=4, DUTY_MAX=8, DW=4.
module tb_breath_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_hold = 8'd0;
  logic       busy;
  logic [2:0] state_o;
  logic [3:0] duty;
  logic       frame_end;
  logic       led;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  breath_seq_ctrl #(
    .TICK_DIV (4),
    .DUTY_MAX (8),
    .DW       (4)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_hold  (cmd_hold),
    .busy      (busy),
    .state_o   (state_o),
    .duty      (duty),
    .frame_end (frame_end),
    .led       (led)
  );

  // breathe, hold 1: per-frame state/duty starting at the apply frame
  int st_b[21] = '{2,2,2,2,2,2,2,2,3,3,4,4,4,4,4,4,4,4,5,5,2};
  int du_b[21] = '{0,1,2,3,4,5,6,7,8,8,8,7,6,5,4,3,2,1,0,0,0};
  // single breath, hold 0
  int st_s[20] = '{2,2,2,2,2,2,2,2,3,4,4,4,4,4,4,4,4,0,0,0};
  int du_s[20] = '{0,1,2,3,4,5,6,7,8,8,7,6,5,4,3,2,1,0,0,0};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fe();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_end && n < 64);
    chk("fe_timeout", {31'd0, frame_end}, 32'd1);
  endtask

  // enter at cycle 0 of a frame, leave at cycle 0 of the next
  task automatic frame_chk(input int es, input int ed);
    int cnt = 0;
    int fe_at = -1;
    chk("state", 32'(state_o), es);
    chk("duty", 32'(duty), ed);
    chk("busy", 32'(busy), 32'(es >= 2 && es <= 5));
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      cnt += 32'(led);
      if (frame_end && fe_at < 0) fe_at = i;
    end
    chk("led_cnt", cnt, 4 * ed);
    chk("fe_pos", fe_at, 30);
  endtask

  // mid-frame one-cycle command; returns at cycle 0 of the apply frame
  task automatic issue(input logic [1:0] m, input logic [7:0] h);
    step(4);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_hold  = h;
    step(1);
    chk("ready_low", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    wait_fe();
    step(1);
  endtask

  initial begin
    int n;

    step(3);
    chk("rst_led", 32'(led), 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_duty", 32'(duty), 0);
    chk("rst_fe", 32'(frame_end), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    wait_fe();
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!frame_end && n < 64);
      chk("fe_period", n, 32);
    end

    // ON
    step(1);
    issue(2'd1, 8'd0);
    chk("on_ready", 32'(cmd_ready), 1);
    frame_chk(1, 8);
    frame_chk(1, 8);

    // OFF
    issue(2'd0, 8'd0);
    frame_chk(0, 0);

    // BREATH hold 1 from OFF, one full period plus the next frame
    issue(2'd2, 8'd1);
    for (int i = 0; i < 21; i++) frame_chk(st_b[i], du_b[i]);
    chk("br_next_duty", 32'(duty), 1);

    // back-pressure: second command held while pending
    step(4);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd1;
    cmd_hold  = 8'd0;
    step(1);
    chk("bp_ready0", 32'(cmd_ready), 0);
    cmd_mode = 2'd0;
    step(3);
    chk("bp_ready1", 32'(cmd_ready), 0);
    wait_fe();
    step(1);
    chk("bp_state_on", 32'(state_o), 1);
    chk("bp_duty_on", 32'(duty), 8);
    chk("bp_ready_up", 32'(cmd_ready), 1);
    step(1);
    chk("bp_captured", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    wait_fe();
    step(1);
    chk("bp_state_off", 32'(state_o), 0);
    chk("bp_duty_off", 32'(duty), 0);
    chk("bp_ready_end", 32'(cmd_ready), 1);

    // SINGLE hold 0
    issue(2'd3, 8'd0);
    for (int i = 0; i < 20; i++) frame_chk(st_s[i], du_s[i]);

    // reset mid-ramp with a pending command
    issue(2'd2, 8'd0);
    repeat (12) wait_fe();
    step(1);
    chk("pre_state", 32'(state_o), 4);
    chk("pre_duty", 32'(duty), 5);
    step(4);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd1;
    step(1);
    chk("pre_pend", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state_o), 0);
    chk("ar_duty", 32'(duty), 0);
    chk("ar_ready", 32'(cmd_ready), 1);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_led", 32'(led), 0);
    chk("ar_fe", 32'(frame_end), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_fe();
      step(1);
      chk("post_state", 32'(state_o), 0);
      chk("post_duty", 32'(duty), 0);
    end
    frame_chk(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
